// File: rtl/modu_mul_serial.sv
// Bit-serial (Blakley interleaved) modular multiplier p = (x*y) mod m.
// One operand bit per cycle, MSB first, with range checking, abort and a fixed latency.
module modu_mul_serial #(
  parameter int NLEN = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            strobe,
  input  logic            abort,
  input  logic [NLEN-1:0] x,
  input  logic [NLEN-1:0] y,
  input  logic [NLEN-1:0] m,
  output logic [NLEN-1:0] p,
  output logic            ready,
  output logic            busy,
  output logic            err
);

  localparam int CW = $clog2(NLEN);

  typedef enum logic [1:0] {IDLE, CHECK, LOOP, DONE} state_t;

  state_t state, state_next;

  logic [NLEN-1:0] x_reg, y_reg, m_reg, acc, acc_next;
  logic [CW-1:0]   idx;
  logic            err_prev;
  logic [NLEN+1:0] t, m1, m2;
  logic            range_bad, last;

  // One Blakley step: t < 3m, so at most two conditional subtractions keep acc < m.
  always_comb begin
    m1 = {2'b00, m_reg};
    m2 = {1'b0, m_reg, 1'b0};
    t  = {1'b0, acc, 1'b0} + (x_reg[NLEN-1] ? {2'b00, y_reg} : '0);
    if (t >= m2) begin
      acc_next = NLEN'(t - m2);
    end else if (t >= m1) begin
      acc_next = NLEN'(t - m1);
    end else begin
      acc_next = NLEN'(t);
    end
    range_bad = (m_reg == '0) || (x_reg >= m_reg) || (y_reg >= m_reg);
    last      = (idx == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (strobe) state_next = CHECK;
      CHECK: begin
        if (abort)          state_next = IDLE;
        else if (range_bad) state_next = DONE;
        else                state_next = LOOP;
      end
      LOOP: begin
        if (abort)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == DONE);
    busy  = (state == CHECK) || (state == LOOP);
  end

  // The x register is shifted left each step so its MSB is always the current bit x[i].
  // err_prev lets an aborted operation restore the flag of the last completed one.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg    <= '0;
      y_reg    <= '0;
      m_reg    <= '0;
      acc      <= '0;
      idx      <= '0;
      p        <= '0;
      err      <= 1'b0;
      err_prev <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe) begin
            x_reg    <= x;
            y_reg    <= y;
            m_reg    <= m;
            err_prev <= err;
            err      <= 1'b0;
          end
        end
        CHECK: begin
          if (abort) begin
            err <= err_prev;
          end else if (range_bad) begin
            err <= 1'b1;
            p   <= '0;
          end else begin
            acc <= '0;
            idx <= CW'(NLEN - 1);
          end
        end
        LOOP: begin
          if (abort) begin
            err <= err_prev;
          end else begin
            acc   <= acc_next;
            x_reg <= x_reg << 1;
            idx   <= idx - CW'(1);
            if (last) p <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modu_mul_serial.sv
// Self-checking bench for modu_mul_serial at NLEN=32 and NLEN=1024,
// comparing against plain (x*y) mod m arithmetic and the documented timing.
module tb_modu_mul_serial;

  localparam int N  = 32;
  localparam int NW = 1024;

  logic          clk = 1'b0;
  logic          rst, strobe, abort;
  logic [N-1:0]  x, y, m, p;
  logic          ready, busy, err;

  logic          strobe_w, abort_w;
  logic [NW-1:0] x_w, y_w, m_w, p_w;
  logic          ready_w, busy_w, err_w;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  modu_mul_serial #(.NLEN(N)) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .abort(abort),
    .x(x), .y(y), .m(m), .p(p), .ready(ready), .busy(busy), .err(err)
  );

  modu_mul_serial #(.NLEN(NW)) dut_w (
    .clk(clk), .rst(rst), .strobe(strobe_w), .abort(abort_w),
    .x(x_w), .y(y_w), .m(m_w), .p(p_w), .ready(ready_w), .busy(busy_w), .err(err_w)
  );

  function automatic logic [N-1:0] model32(input logic [N-1:0] a, b, md);
    logic [63:0] prod;
    logic [63:0] r;
    prod = {32'b0, a} * {32'b0, b};
    r = prod % {32'b0, md};
    return r[N-1:0];
  endfunction

  task automatic start32(input logic [N-1:0] xv, yv, mv);
    @(negedge clk);
    x = xv; y = yv; m = mv; strobe = 1'b1;
    @(posedge clk);
    #1 strobe = 1'b0;
  endtask

  // Called just after the accepting edge; returns at the negedge of the ready cycle.
  task automatic wait_ready32(output int cyc, output int bcnt);
    bit got = 0;
    cyc = 1; bcnt = 0;
    for (int n = 0; n < N + 10 && !got; n++) begin
      @(negedge clk);
      if (ready) got = 1;
      else begin
        if (busy) bcnt++;
        @(posedge clk);
        cyc++;
      end
    end
    if (!got) cyc = -1;
  endtask

  task automatic run_op32(input logic [N-1:0] xv, yv, mv, output int cyc, output int bcnt);
    start32(xv, yv, mv);
    wait_ready32(cyc, bcnt);
  endtask

  task automatic test_reset;
    rst = 1'b1; strobe = 1'b0; abort = 1'b0; x = '0; y = '0; m = '0;
    strobe_w = 1'b0; abort_w = 1'b0; x_w = '0; y_w = '0; m_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({p, ready, busy, err} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset32: p=%0h ready=%b busy=%b err=%b, required all zero", p, ready, busy, err);
    end
    compared++;
    if (p_w !== '0 || {ready_w, busy_w, err_w} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset1024: ready=%b busy=%b err=%b or p nonzero, required all zero", ready_w, busy_w, err_w);
    end
  endtask

  task automatic test_basic;
    int cyc, bcnt;
    run_op32(32'd6, 32'd5, 32'd7, cyc, bcnt);
    compared++;
    if (cyc !== N + 2) begin
      mismatched++;
      $display("[TB] FAIL basic_latency: got %0d cycles, required %0d", cyc, N + 2);
    end
    compared++;
    if (bcnt !== N + 1) begin
      mismatched++;
      $display("[TB] FAIL basic_busy: busy for %0d cycles, required %0d", bcnt, N + 1);
    end
    compared++;
    if (p !== 32'd2 || err !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_result: p=%0d err=%b busy=%b, required p=2 err=0 busy=0", p, err, busy);
    end
    @(negedge clk);
    compared++;
    if (ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_pulse: ready=%b one cycle later, required 0", ready);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bcnt;
    repeat (3) @(negedge clk);
    compared++;
    if (p !== 32'd2) begin
      mismatched++;
      $display("[TB] FAIL hold_idle: p=%0d, required 2", p);
    end
    run_op32(32'd5, 32'd13, 32'd17, cyc, bcnt);
    compared++;
    if (p !== 32'd14 || err !== 1'b0 || cyc !== N + 2) begin
      mismatched++;
      $display("[TB] FAIL b2b_result: p=%0d err=%b cyc=%0d, required p=14 err=0 cyc=%0d", p, err, cyc, N + 2);
    end
  endtask

  task automatic test_done_strobe;
    x = 32'd6; y = 32'd5; m = 32'd7; strobe = 1'b1;
    @(posedge clk);
    #1 strobe = 1'b0;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || ready !== 1'b0 || p !== 32'd14) begin
      mismatched++;
      $display("[TB] FAIL done_strobe: busy=%b ready=%b p=%0d, required busy=0 ready=0 p=14", busy, ready, p);
    end
  endtask

  task automatic test_range;
    int cyc, bcnt;
    logic [N-1:0] cases [3][3] = '{'{32'd5, 32'd3, 32'd0}, '{32'd17, 32'd3, 32'd17}, '{32'd2, 32'd20, 32'd17}};
    for (int i = 0; i < 3; i++) begin
      run_op32(cases[i][0], cases[i][1], cases[i][2], cyc, bcnt);
      compared++;
      if (err !== 1'b1 || p !== '0 || cyc !== 2) begin
        mismatched++;
        $display("[TB] FAIL range_%0d: err=%b p=%0d cyc=%0d, required err=1 p=0 cyc=2", i, err, p, cyc);
      end
    end
    run_op32(32'd5, 32'd13, 32'd17, cyc, bcnt);
    compared++;
    if (err !== 1'b0 || p !== 32'd14) begin
      mismatched++;
      $display("[TB] FAIL range_clear: err=%b p=%0d, required err=0 p=14", err, p);
    end
  endtask

  task automatic test_boundary;
    int cyc, bcnt;
    logic [N-1:0] mv = 32'hFFFF_FFFB;
    run_op32(32'd0, mv - 1, mv, cyc, bcnt);
    compared++;
    if (p !== 32'd0 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bound_zero: p=%0h err=%b, required p=0 err=0", p, err);
    end
    run_op32(mv - 1, mv - 1, mv, cyc, bcnt);
    compared++;
    if (p !== 32'd1 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bound_max: p=%0h err=%b, required p=1 err=0", p, err);
    end
  endtask

  task automatic abort_at_loop10;
    repeat (10) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  task automatic test_abort;
    int cyc, bcnt, seen;
    start32(32'd6, 32'd5, 32'd7);
    abort_at_loop10();
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || ready !== 1'b0 || p !== 32'd1 || err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_state: busy=%b ready=%b p=%0d err=%b, required 0 0 1 0", busy, ready, p, err);
    end
    seen = 0;
    for (int i = 0; i < N + 8; i++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("[TB] FAIL abort_noready: ready seen %0d times, required 0", seen);
    end
    @(negedge clk);
    x = 32'd5; y = 32'd13; m = 32'd17; strobe = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 strobe = 1'b0; abort = 1'b0;
    wait_ready32(cyc, bcnt);
    compared++;
    if (p !== 32'd14 || cyc !== N + 2) begin
      mismatched++;
      $display("[TB] FAIL abort_idle: p=%0d cyc=%0d, required p=14 cyc=%0d", p, cyc, N + 2);
    end
    run_op32(32'd17, 32'd3, 32'd17, cyc, bcnt);
    start32(32'd6, 32'd5, 32'd7);
    abort_at_loop10();
    @(negedge clk);
    compared++;
    if (err !== 1'b1 || p !== 32'd0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_err_hold: err=%b p=%0d busy=%b, required err=1 p=0 busy=0", err, p, busy);
    end
  endtask

  task automatic test_strobe_ignored;
    int cyc, bcnt;
    start32(32'd6, 32'd5, 32'd7);
    repeat (4) @(negedge clk);
    x = 32'd9; y = 32'd9; m = 32'd11; strobe = 1'b1;
    @(posedge clk);
    #1 strobe = 1'b0;
    repeat (6) @(negedge clk);
    x = 32'd1; y = 32'd1; m = 32'd3; strobe = 1'b1;
    @(posedge clk);
    #1 strobe = 1'b0;
    wait_ready32(cyc, bcnt);
    compared++;
    if (p !== 32'd2 || err !== 1'b0 || cyc < 0) begin
      mismatched++;
      $display("[TB] FAIL strobe_busy: p=%0d err=%b cyc=%0d, required p=2 err=0", p, err, cyc);
    end
    @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL strobe_queue: busy=%b after ready, required 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    start32(32'd5, 32'd13, 32'd17);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    compared++;
    if ({p, ready, busy, err} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid: p=%0d ready=%b busy=%b err=%b, required all zero", p, ready, busy, err);
    end
    seen = 0;
    for (int i = 0; i < N + 8; i++) begin
      @(negedge clk);
      if (ready || busy) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("[TB] FAIL reset_idle: busy/ready seen %0d times, required 0", seen);
    end
  endtask

  task automatic test_random_32;
    int cyc, bcnt;
    logic [N-1:0] xv, yv, mv, expv;
    for (int i = 0; i < 500; i++) begin
      mv = ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, 100)) : $urandom;
      if (mv == '0) mv = 32'd1;
      xv = $urandom % mv;
      yv = $urandom % mv;
      expv = model32(xv, yv, mv);
      run_op32(xv, yv, mv, cyc, bcnt);
      compared++;
      if (p !== expv || err !== 1'b0 || cyc !== N + 2) begin
        mismatched++;
        $display("[TB] FAIL rand32_%0d: x=%0h y=%0h m=%0h p=%0h err=%b cyc=%0d, required p=%0h err=0 cyc=%0d",
                 i, xv, yv, mv, p, err, cyc, expv, N + 2);
      end
    end
  endtask

  task automatic test_random_1024;
    logic [NW-1:0]   xv, yv, mv, expv;
    logic [2*NW-1:0] prod, rem;
    int cyc;
    bit got;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < NW / 32; k++) mv[k*32 +: 32] = $urandom;
      if (i % 3 == 1) mv[NW-1 -: 32] = '0;
      if (mv == '0) mv[0] = 1'b1;
      for (int k = 0; k < NW / 32; k++) xv[k*32 +: 32] = $urandom;
      for (int k = 0; k < NW / 32; k++) yv[k*32 +: 32] = $urandom;
      rem  = {{NW{1'b0}}, xv} % {{NW{1'b0}}, mv};
      xv   = rem[NW-1:0];
      rem  = {{NW{1'b0}}, yv} % {{NW{1'b0}}, mv};
      yv   = rem[NW-1:0];
      prod = {{NW{1'b0}}, xv} * {{NW{1'b0}}, yv};
      rem  = prod % {{NW{1'b0}}, mv};
      expv = rem[NW-1:0];
      @(negedge clk);
      x_w = xv; y_w = yv; m_w = mv; strobe_w = 1'b1;
      @(posedge clk);
      #1 strobe_w = 1'b0;
      cyc = 1; got = 0;
      for (int n = 0; n < NW + 10 && !got; n++) begin
        @(negedge clk);
        if (ready_w) got = 1;
        else begin
          @(posedge clk);
          cyc++;
        end
      end
      compared++;
      if (!got || p_w !== expv || err_w !== 1'b0 || cyc !== NW + 2) begin
        mismatched++;
        $display("[TB] FAIL rand1024_%0d: got_ready=%b err=%b cyc=%0d low_p=%0h, required err=0 cyc=%0d low_p=%0h",
                 i, got, err_w, cyc, p_w[31:0], NW + 2, expv[31:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_done_strobe();
    test_range();
    test_boundary();
    test_abort();
    test_strobe_ignored();
    test_reset_mid();
    test_random_32();
    test_random_1024();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
